led_data_tx: RTL and testbench
==============================

# led_data_tx

Serial frame-data transmitter for the LED display driver's data port. It pulls 16-bit grayscale words from an upstream word source with a valid/ready handshake. Each word goes out on the DAI/DEN serial interface, LSB first, one bit per DCK cycle, with DEN framing every word. After a full frame of words it signals completion, and the host can then start the GCK/Vsync scan phase.

## Interface
Parameters:
- WORD_W, 16: bits per serialized word.
- WORDS_PER_FRAME, 512: words per frame.
- GAP, 2: DEN-low cycles after each word (minimum 1).

Ports:
- DCK  in  1  data clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to send a frame; sampled only in IDLE.
- wd_valid  in  1  upstream word available.
- wd_data  in  WORD_W  upstream word.
- wd_ready  out  1  word accepted this cycle when wd_valid is high.
- DAI  out  1  serial data to the driver.
- DEN  out  1  data enable; high while a word's bits are on DAI.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last word's gap.
- word_cnt  out  clog2(WORDS_PER_FRAME)+1  words fully sent in the current frame.

## Operation
- States: IDLE, LOAD, SHIFT, GAP, DONE.
- IDLE: DEN=0, DAI=0, busy=0. If start=1, word_cnt is cleared to 0 and the next state is LOAD.
- LOAD:
  - wd_ready=1, decoded combinationally from state==LOAD.
  - On wd_valid=1, wd_data is captured into the shift register, the bit index is cleared, and the next state is SHIFT.
  - On wd_valid=0, the block stays in LOAD with DEN=0 and DAI=0. This is the underrun stall; there is no timeout.
- SHIFT:
  - DEN=1 and DAI=shreg[0], all registered outputs.
  - The shift register shifts right each cycle.
  - After WORD_W cycles (bit index WORD_W-1), word_cnt increments and the next state is GAP.
- GAP:
  - DEN=0, DAI=0 for GAP cycles.
  - On the last gap cycle, the next state is DONE if word_cnt==WORDS_PER_FRAME, otherwise LOAD.
- DONE: frame_done=1 for exactly one cycle, then IDLE. word_cnt holds WORDS_PER_FRAME until the next start.
- Bit order: bit 0 is sent first, bit WORD_W-1 last.
- start is ignored while busy=1. wd_ready is 0 outside LOAD, so no word is ever consumed outside LOAD.

## Timing
- Reset values: DAI=0, DEN=0, wd_ready=0, busy=0, frame_done=0, word_cnt=0, state=IDLE.
- All outputs except wd_ready are registered.
- start is sampled at edge t0. LOAD is active in cycle t0+1, so wd_ready=1 in that cycle.
- A word accepted at edge tA gives DEN=1 with DAI=bit0 from tA+1 through tA+16 (bit15 during the cycle after edge tA+15). DEN falls at edge tA+16.
- Word period with continuous valid is 1 + WORD_W + GAP = 19 cycles at the defaults.
- A full frame with no stalls takes 512×19 = 9728 cycles from the first LOAD to DONE.
- frame_done asserts the cycle after the final GAP cycle, and busy falls one cycle after that.
- Reset mid-frame: the next edge forces IDLE with all outputs at reset values. The partially sent word is abandoned and no frame_done is issued.
- start and rst high in the same cycle: reset wins.
- Underrun during LOAD stretches the inter-word DEN-low interval. It never truncates a word, because DEN stays high for exactly WORD_W consecutive cycles per word.

## Test plan
- Reset state: hold rst for 3 cycles, then check every output is 0 and state is IDLE. Pulse start with wd_valid=0 → busy=1 and wd_ready=1, DEN stays 0 indefinitely.
- Single word: WORDS_PER_FRAME=1, wd_data=16'hA5C3 valid continuously.
  - DAI sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 with DEN high for exactly 16 cycles.
  - DEN then low for 2 cycles, frame_done pulses once, busy drops.
- Full frame: default parameters, source supplies words 0..511 with continuous valid.
  - Deserialize DAI/DEN into a model of the driver's receiver and check all 512 words in order.
  - Check frame_done at cycle 9728 after the first LOAD and word_cnt=512.
- Underrun stall: drop wd_valid for 7 cycles before word 3 → inter-word DEN-low gap is 2+1+7 cycles. Word 3's contents are intact and wd_ready is never high outside LOAD.
- Reset mid-word: assert rst during bit 9 of word 5 → DEN=0 and DAI=0 the next cycle, and no frame_done. A new start then sends a full frame from word 0.
- Start while busy: pulse start during SHIFT of word 2 → no effect on word_cnt, the frame completes normally, and exactly one frame_done is issued.

Source files
------------

// File: rtl/led_data_tx.sv
// led_data_tx: serializes 16-bit grayscale words onto DAI/DEN, LSB first.
// One DEN window per word, GAP idle cycles between words, pulse at frame end.
module led_data_tx #(
  parameter int WORD_W          = 16,
  parameter int WORDS_PER_FRAME = 512,
  parameter int GAP             = 2
) (
  input  logic                               DCK,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               wd_valid,
  input  logic [WORD_W-1:0]                  wd_data,
  output logic                               wd_ready,
  output logic                               DAI,
  output logic                               DEN,
  output logic                               busy,
  output logic                               frame_done,
  output logic [$clog2(WORDS_PER_FRAME):0]   word_cnt
);

  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int CW = $clog2(WORDS_PER_FRAME) + 1;

  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'(GAP - 1);
  localparam logic [CW-1:0] FRAME_N  = CW'(WORDS_PER_FRAME);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] GAPS  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]        state;
  logic [WORD_W-1:0] shreg;
  logic [BW-1:0]     bit_idx;
  logic [GW-1:0]     gap_cnt;

  assign wd_ready = (state == LOAD);

  always_ff @(posedge DCK) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      gap_cnt    <= '0;
      word_cnt   <= '0;
      DAI        <= 1'b0;
      DEN        <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            word_cnt <= '0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          // bit 0 goes straight to DAI; shreg keeps the bits still to send
          if (wd_valid) begin
            shreg   <= wd_data >> 1;
            DAI     <= wd_data[0];
            DEN     <= 1'b1;
            bit_idx <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_idx == LAST_BIT) begin
            DEN      <= 1'b0;
            DAI      <= 1'b0;
            gap_cnt  <= '0;
            word_cnt <= word_cnt + 1'b1;
            state    <= GAPS;
          end else begin
            DAI     <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 1'b1;
          end
        end
        GAPS: begin
          if (gap_cnt == LAST_GAP) begin
            if (word_cnt == FRAME_N) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              state <= LOAD;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_data_tx.sv
// tb_led_data_tx: directed bench for led_data_tx.
// Receiver model deserializes DAI/DEN; each test task checks its own results.
module tb_led_data_tx;

  logic DCK = 1'b0;
  always #5 DCK = ~DCK;

  logic        rst, start, wd_valid;
  logic [15:0] wd_data;
  logic        wd_ready, DAI, DEN, busy, frame_done;
  logic [9:0]  word_cnt;

  logic        s_start, s_valid;
  logic [15:0] s_data;
  logic        s_ready, s_dai, s_den, s_busy, s_done;
  logic [0:0]  s_cnt;

  led_data_tx dut (
    .DCK(DCK), .rst(rst), .start(start),
    .wd_valid(wd_valid), .wd_data(wd_data), .wd_ready(wd_ready),
    .DAI(DAI), .DEN(DEN), .busy(busy),
    .frame_done(frame_done), .word_cnt(word_cnt)
  );

  led_data_tx #(.WORDS_PER_FRAME(1)) dut1 (
    .DCK(DCK), .rst(rst), .start(s_start),
    .wd_valid(s_valid), .wd_data(s_data), .wd_ready(s_ready),
    .DAI(s_dai), .DEN(s_den), .busy(s_busy),
    .frame_done(s_done), .word_cnt(s_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int src_idx, stall_at, stall_len, stall_cnt;
  bit src_en;
  int cyc = 0;
  int cyc0;
  logic [15:0] rx_sh;
  int rx_bits, low_run, fd_count, ready_bad;
  logic [15:0] rx_words[$];
  int rx_lens[$];
  int rx_gaps[$];

  task automatic tick();
    logic acc;
    acc = wd_valid && wd_ready;
    if (!wd_valid && wd_ready && src_idx == stall_at) stall_cnt++;
    @(posedge DCK);
    #1;
    cyc++;
    if (acc) src_idx++;
    wd_data  = 16'(src_idx);
    wd_valid = src_en && !(src_idx == stall_at && stall_cnt < stall_len);
    if (DEN === 1'b1) begin
      if (rx_bits == 0) rx_gaps.push_back(low_run);
      rx_sh = {DAI, rx_sh[15:1]};
      rx_bits++;
      low_run = 0;
    end else begin
      if (rx_bits != 0) begin
        rx_words.push_back(rx_sh);
        rx_lens.push_back(rx_bits);
        rx_bits = 0;
      end
      low_run++;
    end
    if (frame_done === 1'b1) fd_count++;
    if (wd_ready && (DEN || !busy || frame_done)) ready_bad++;
  endtask

  task automatic start_frame();
    rx_words.delete();
    rx_lens.delete();
    rx_gaps.delete();
    rx_bits   = 0;
    low_run   = 0;
    fd_count  = 0;
    ready_bad = 0;
    src_idx   = 0;
    stall_cnt = 0;
    src_en    = 1'b1;
    wd_data   = 16'h0;
    wd_valid  = !(stall_at == 0 && stall_len > 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc0 = cyc;
  endtask

  task automatic run_to_done();
    int guard;
    guard = 0;
    while (frame_done !== 1'b1 && guard < 12000) begin
      tick();
      guard++;
    end
  endtask

  function automatic int word_errs();
    int e;
    e = 0;
    if (rx_words.size() != 512) e++;
    foreach (rx_words[i])
      if (rx_words[i] !== 16'(i) || rx_lens[i] != 16) e++;
    return e;
  endfunction

  task automatic test_reset();
    int den_hi, rdy_lo;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    n_cmp++;
    if ({DAI, DEN, wd_ready, busy, frame_done} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 00000",
               {DAI, DEN, wd_ready, busy, frame_done});
    end
    n_cmp++;
    if (word_cnt !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_word_cnt: got %0d want 0", word_cnt);
    end
    src_en = 1'b0;
    wd_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || wd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL start_load: busy=%b ready=%b want 1 1", busy, wd_ready);
    end
    den_hi = 0;
    rdy_lo = 0;
    repeat (40) begin
      tick();
      if (DEN !== 1'b0) den_hi++;
      if (wd_ready !== 1'b1) rdy_lo++;
    end
    n_cmp++;
    if (den_hi != 0 || rdy_lo != 0) begin
      n_bad++;
      $display("FAIL underrun_idle: den_hi=%0d rdy_lo=%0d want 0 0",
               den_hi, rdy_lo);
    end
    rst = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || wd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_beats_start: busy=%b ready=%b want 0 0",
               busy, wd_ready);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [0:15] seq;
    int bad;
    seq = 16'b1100_0011_1010_0101;
    s_data = 16'hA5C3;
    s_valid = 1'b1;
    s_start = 1'b1;
    @(posedge DCK);
    #1;
    s_start = 1'b0;
    n_cmp++;
    if (s_ready !== 1'b1 || s_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_load: ready=%b busy=%b want 1 1", s_ready, s_busy);
    end
    @(posedge DCK);
    #1;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (s_den !== 1'b1 || s_dai !== seq[i]) bad++;
      @(posedge DCK);
      #1;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL single_bits: %0d bad bit cycles want 0", bad);
    end
    n_cmp++;
    if (s_den !== 1'b0 || s_dai !== 1'b0 || s_done !== 1'b0) begin
      n_bad++;
      $display("FAIL single_gap1: den=%b dai=%b done=%b want 0 0 0",
               s_den, s_dai, s_done);
    end
    @(posedge DCK);
    #1;
    n_cmp++;
    if (s_den !== 1'b0 || s_done !== 1'b0) begin
      n_bad++;
      $display("FAIL single_gap2: den=%b done=%b want 0 0", s_den, s_done);
    end
    @(posedge DCK);
    #1;
    n_cmp++;
    if (s_done !== 1'b1 || s_busy !== 1'b1 || s_den !== 1'b0) begin
      n_bad++;
      $display("FAIL single_done: done=%b busy=%b den=%b want 1 1 0",
               s_done, s_busy, s_den);
    end
    @(posedge DCK);
    #1;
    n_cmp++;
    if (s_done !== 1'b0 || s_busy !== 1'b0 || s_cnt !== 1'b1) begin
      n_bad++;
      $display("FAIL single_idle: done=%b busy=%b cnt=%b want 0 0 1",
               s_done, s_busy, s_cnt);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_full_frame();
    int n, gbad;
    start_frame();
    run_to_done();
    n = cyc - cyc0;
    n_cmp++;
    if (n != 9728) begin
      n_bad++;
      $display("FAIL full_latency: got %0d cycles want 9728", n);
    end
    n_cmp++;
    if (word_cnt !== 10'd512) begin
      n_bad++;
      $display("FAIL full_word_cnt: got %0d want 512", word_cnt);
    end
    n_cmp++;
    if (word_errs() != 0) begin
      n_bad++;
      $display("FAIL full_words: %0d errors over %0d words want 0/512",
               word_errs(), rx_words.size());
    end
    gbad = 0;
    foreach (rx_gaps[i]) if (i > 0 && rx_gaps[i] != 3) gbad++;
    n_cmp++;
    if (gbad != 0 || ready_bad != 0) begin
      n_bad++;
      $display("FAIL full_gaps: bad_gaps=%0d ready_bad=%0d want 0 0",
               gbad, ready_bad);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || fd_count != 1 || word_cnt !== 10'd512) begin
      n_bad++;
      $display("FAIL full_end: busy=%b done_pulses=%0d cnt=%0d want 0 1 512",
               busy, fd_count, word_cnt);
    end
  endtask

  task automatic test_underrun();
    int n, g2, g3;
    stall_at = 3;
    stall_len = 7;
    start_frame();
    run_to_done();
    n = cyc - cyc0;
    g2 = (rx_gaps.size() > 3) ? rx_gaps[2] : -1;
    g3 = (rx_gaps.size() > 3) ? rx_gaps[3] : -1;
    n_cmp++;
    if (g3 != 10 || g2 != 3) begin
      n_bad++;
      $display("FAIL underrun_gap: gap2=%0d gap3=%0d want 3 10", g2, g3);
    end
    n_cmp++;
    if (word_errs() != 0 || ready_bad != 0) begin
      n_bad++;
      $display("FAIL underrun_words: errs=%0d ready_bad=%0d want 0 0",
               word_errs(), ready_bad);
    end
    n_cmp++;
    if (n != 9735) begin
      n_bad++;
      $display("FAIL underrun_latency: got %0d want 9735", n);
    end
    stall_at = -1;
    stall_len = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    int g, n;
    start_frame();
    g = 0;
    while (!(rx_words.size() == 5 && rx_bits == 10) && g < 2000) begin
      tick();
      g++;
    end
    n_cmp++;
    if (g >= 2000) begin
      n_bad++;
      $display("FAIL mid_reach: no bit 9 of word 5 in %0d cycles", g);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (DEN !== 1'b0 || DAI !== 1'b0 || busy !== 1'b0 ||
        word_cnt !== 10'd0) begin
      n_bad++;
      $display("FAIL mid_reset: den=%b dai=%b busy=%b cnt=%0d want 0 0 0 0",
               DEN, DAI, busy, word_cnt);
    end
    repeat (40) tick();
    n_cmp++;
    if (fd_count != 0) begin
      n_bad++;
      $display("FAIL mid_no_done: got %0d pulses want 0", fd_count);
    end
    start_frame();
    run_to_done();
    n = cyc - cyc0;
    n_cmp++;
    if (n != 9728 || word_errs() != 0) begin
      n_bad++;
      $display("FAIL mid_refill: cycles=%0d errs=%0d want 9728 0",
               n, word_errs());
    end
    tick();
  endtask

  task automatic test_start_busy();
    int g, n;
    start_frame();
    g = 0;
    while (!(rx_words.size() == 2 && rx_bits == 4) && g < 2000) begin
      tick();
      g++;
    end
    n_cmp++;
    if (word_cnt !== 10'd2 || DEN !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_pre: cnt=%0d den=%b want 2 1", word_cnt, DEN);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (word_cnt !== 10'd2 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_start: cnt=%0d busy=%b want 2 1", word_cnt, busy);
    end
    run_to_done();
    n = cyc - cyc0;
    n_cmp++;
    if (n != 9728 || word_cnt !== 10'd512 || word_errs() != 0) begin
      n_bad++;
      $display("FAIL busy_frame: cycles=%0d cnt=%0d errs=%0d want 9728 512 0",
               n, word_cnt, word_errs());
    end
    repeat (25) tick();
    n_cmp++;
    if (fd_count != 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_one_done: pulses=%0d busy=%b want 1 0",
               fd_count, busy);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    wd_valid = 1'b0;
    wd_data = 16'h0;
    src_en = 1'b0;
    src_idx = 0;
    stall_at = -1;
    stall_len = 0;
    stall_cnt = 0;
    rx_sh = 16'h0;
    rx_bits = 0;
    low_run = 0;
    fd_count = 0;
    ready_bad = 0;
    s_start = 1'b0;
    s_valid = 1'b0;
    s_data = 16'h0;
    test_reset();
    test_single();
    test_full_frame();
    test_underrun();
    test_reset_mid();
    test_start_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
